user_mgr_arbiter: RTL
=====================

// Module: user_mgr_arbiter
// PURPOSE
//   Shares the single user-domain OBI manager port among NumReq user requesters (EDM engine, future masters).
//   Round-robin A-channel arbitration; an in-order ID FIFO routes each R-channel response back to its issuer.
//   Sits in user_domain between the user masters and the user_mgr_obi_req_o/rsp_i pair to the Croc crossbar.
// PARAMETERS
//   NumReq     2   number of requester ports (>=1)
//   AddrWidth  32  OBI address width
//   DataWidth  32  OBI data width; be width = DataWidth/8
//   MaxTrans   4   max outstanding transactions (ID FIFO depth, >=1)
// PORTS
//   clk_i        in   1                  clock
//   rst_i        in   1                  synchronous reset, active-high
//   req_i        in   NumReq             per-requester A-channel request
//   gnt_o        out  NumReq             per-requester grant (onehot or zero)
//   addr_i       in   NumReq*AddrWidth   per-requester address
//   we_i         in   NumReq             per-requester write enable
//   be_i         in   NumReq*DataWidth/8 per-requester byte enables
//   wdata_i      in   NumReq*DataWidth   per-requester write data
//   rvalid_o     out  NumReq             per-requester response valid
//   rdata_o      out  DataWidth          response data, broadcast
//   err_o        out  1                  response error, broadcast
//   mgr_req_o    out  1                  downstream request
//   mgr_gnt_i    in   1                  downstream grant
//   mgr_addr_o/we_o/be_o/wdata_o  out    selected A-channel fields
//   mgr_rvalid_i/rdata_i/err_i    in     downstream R channel
//   unexp_rsp_o  out  1                  sticky: rvalid seen with empty ID FIFO
//   gnt_cnt_o    out  NumReq*32          per-requester grant counters (macro)
// BEHAVIOUR
//   - Clock clk_i only; reset rst_i synchronous active-high. While rst_i=1 all outputs are 0.
//   - Reset: rr pointer=0, lock=0, FIFO empty, unexp_rsp_o=0, counters=0.
//   - Arbitration: combinational; first req_i[k] at/after rr pointer wins. Pass-through, zero added latency.
//   - Lock: if mgr_req_o=1 and mgr_gnt_i=0, winner index registered and held next cycle regardless of other
//     requests (OBI stability). Lock clears on the grant cycle.
//   - Handshake: gnt_o[win]=mgr_gnt_i & mgr_req_o; other gnt_o bits 0. On handshake: push win into FIFO,
//     rr pointer <= win+1 (wrap at NumReq-1 -> 0).
//   - FIFO full: mgr_req_o=0, all gnt_o=0. Same-cycle pop does NOT unblock issue (next cycle does).
//   - Response: mgr_rvalid_i with FIFO non-empty -> rvalid_o[head]=1 that cycle, head popped; rdata_o/err_o
//     pass through. Zero-cycle latency.
//   - Push and pop same cycle (not full): both happen; occupancy unchanged.
//   - mgr_rvalid_i with FIFO empty: response dropped, no rvalid_o, unexp_rsp_o set until reset.
//   - Reset mid-transfer: outstanding IDs discarded; late responses after reset raise unexp_rsp_o.
//   - NumReq=1: arbiter degenerates to pass-through with FIFO gating; pointer stays 0.
// CONFIGURATION
//   USER_MGR_ARB_PERF_EN defined: per-requester 32-bit grant counters, +1 per handshake, wrap 0xFFFFFFFF->0.
//   Not defined: no counter flops; gnt_cnt_o tied to 0. Port list identical in both builds.
// STRUCTURE
//   - user_pkg: NumUserMgrReq constant, user_mgr_idx_t = logic [$clog2(NumReq)-1:0] (min width 1).
//   - Sub-module user_mgr_arb_fifo: sync FIFO of user_mgr_idx_t, depth MaxTrans, push/pop/full/empty/head.
//   - Top holds rr pointer, lock register, arbitration, muxing, sticky flag, optional counters.
// TESTING
//   1 Reset then req_i=2'b11 held, mgr_gnt_i=1 each cycle -> grants alternate 0,1,0,1; FIFO fills after 4 grants.
//   2 req_i[1]=1, mgr_gnt_i=0 for 3 cycles, req_i[0] rises cycle 2 -> mgr_addr_o stays requester 1, grant to 1.
//   3 MaxTrans=4 issued, no rvalid -> mgr_req_o=0; rvalid on cycle N -> issue resumes cycle N+1, not N.
//   4 Grants 0,1,0 then three rvalid with rdata 0xA,0xB,0xC -> rvalid_o[0],[1],[0] in order with matching rdata.
//   5 mgr_rvalid_i=1 with FIFO empty -> no rvalid_o, unexp_rsp_o=1 until rst_i pulse clears it.
//   6 With USER_MGR_ARB_PERF_EN: 5 grants to req 1 -> gnt_cnt_o[1]=5; without macro gnt_cnt_o=0.

Source files
------------

// File: rtl/user_mgr_arbiter_pkg.sv
// Shared types and constants for the user-domain manager arbiter.
// Holds the default requester count and the requester index type that the
// ID FIFO carries.
package user_mgr_arbiter_pkg;

  localparam int NumUserMgrReq = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NumUserMgrReq)-1:0] user_mgr_idx_t;

endpackage

// File: rtl/user_mgr_arb_fifo.sv
// In-order ID FIFO: remembers which requester issued each outstanding
// transaction so the response can be steered back to it.
// Push is ignored when full, pop is ignored when empty.
module user_mgr_arb_fifo #(
  parameter int Width = 1,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q;
  logic [PtrW-1:0]  rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  // Pointer and occupancy tracking; reset discards everything outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing the single user-domain OBI manager port among
// NumReq requesters. A-channel is a zero-latency pass-through of the winner;
// an in-order ID FIFO routes R-channel responses back to their issuer.
// Optional build macro USER_MGR_ARB_PERF_EN adds per-requester 32-bit grant
// counters; without it gnt_cnt_o is tied to zero (port list unchanged).
module user_mgr_arbiter
  import user_mgr_arbiter_pkg::*;
#(
  parameter int NumReq    = NumUserMgrReq,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxTrans  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*DataWidth/8-1:0] be_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          err_o,
  output logic                          mgr_req_o,
  input  logic                          mgr_gnt_i,
  output logic [AddrWidth-1:0]          mgr_addr_o,
  output logic                          mgr_we_o,
  output logic [DataWidth/8-1:0]        mgr_be_o,
  output logic [DataWidth-1:0]          mgr_wdata_o,
  input  logic                          mgr_rvalid_i,
  input  logic [DataWidth-1:0]          mgr_rdata_i,
  input  logic                          mgr_err_i,
  output logic                          unexp_rsp_o,
  output logic [NumReq*32-1:0]          gnt_cnt_o
);

  localparam int IdxW = idx_width(NumReq);
  localparam int BeW  = DataWidth / 8;

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;
  logic            unexp_q;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] rr_next;
  logic [IdxW-1:0] head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            hs;
  logic            pop;
  logic            stall;

  // Round-robin search: first active request at or after the pointer.
  always_comb begin
    int  j;
    logic found;
    arb_idx = rr_q;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(rr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!found && req_i[j]) begin
        found   = 1'b1;
        arb_idx = IdxW'(j);
      end
    end
  end

  // A stalled request keeps its winner so the A-channel stays stable.
  assign win     = lock_q ? lock_idx_q : arb_idx;
  assign rr_next = (win == IdxW'(NumReq - 1)) ? '0 : win + 1'b1;

  // Registered full blocks issue; a same-cycle pop only helps next cycle.
  assign mgr_req_o = ~rst_i & ~fifo_full & (lock_q | (|req_i));
  assign hs        = mgr_req_o & mgr_gnt_i;
  assign stall     = mgr_req_o & ~mgr_gnt_i;
  assign pop       = ~rst_i & mgr_rvalid_i & ~fifo_empty;

  // Winner field mux, grant steering and response steering.
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    mgr_addr_o  = '0;
    mgr_we_o    = 1'b0;
    mgr_be_o    = '0;
    mgr_wdata_o = '0;
    rdata_o     = '0;
    err_o       = 1'b0;
    if (!rst_i) begin
      mgr_addr_o  = addr_i[win*AddrWidth +: AddrWidth];
      mgr_we_o    = we_i[win];
      mgr_be_o    = be_i[win*BeW +: BeW];
      mgr_wdata_o = wdata_i[win*DataWidth +: DataWidth];
      rdata_o     = mgr_rdata_i;
      err_o       = mgr_err_i;
      if (hs)  gnt_o[win]     = 1'b1;
      if (pop) rvalid_o[head] = 1'b1;
    end
  end

  // Pointer advance, stall lock and sticky unexpected-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      unexp_q    <= 1'b0;
    end else begin
      if (hs) rr_q <= rr_next;
      lock_q <= stall;
      if (stall) lock_idx_q <= win;
      if (mgr_rvalid_i && fifo_empty) unexp_q <= 1'b1;
    end
  end

  assign unexp_rsp_o = unexp_q & ~rst_i;

  user_mgr_arb_fifo #(
    .Width(IdxW),
    .Depth(MaxTrans)
  ) i_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (hs),
    .data_i (win),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

`ifdef USER_MGR_ARB_PERF_EN
  logic [31:0] cnt_q [NumReq];

  // Per-requester handshake counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumReq; i++) cnt_q[i] <= '0;
    end else if (hs) begin
      cnt_q[win] <= cnt_q[win] + 32'd1;
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    gnt_cnt_o = '0;
    if (!rst_i) begin
      for (int i = 0; i < NumReq; i++) gnt_cnt_o[i*32 +: 32] = cnt_q[i];
    end
  end
`else
  assign gnt_cnt_o = '0;
`endif

endmodule
